cache_repl_ctrl: RTL
====================

Name: cache_repl_ctrl

Overview:
Parametrised way-replacement controller for the set-associative cache. It keeps per-set valid bits, a round-robin pointer and tree-PLRU state. On request it returns a registered one-hot write-enable for the victim way. It also supports runtime policy select, a global way-lock mask, per-way invalidate and a full flush. The controller sits between the tag-compare stage (hit/touch updates) and the data/tag array write-enable decode.

Parameters:
NUM_SETS, 4, number of sets; power of 2, >=2
NUM_WAYS, 4, ways per set; power of 2, >=2
SET_W, $clog2(NUM_SETS), set index width (derived)
WAY_W, $clog2(NUM_WAYS), way index width (derived)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; asynchronous, active-low
i_mode  in  1  0 = round-robin, 1 = tree-PLRU; sampled every cycle
i_flush  in  1  synchronous clear of all valid bits, RR pointers and PLRU bits
i_lock_mask  in  NUM_WAYS  1 = way excluded from allocation in every set
i_acc_valid  in  1  hit touch strobe
i_acc_set  in  SET_W  set of the hit
i_acc_way  in  WAY_W  way of the hit
i_inv_valid  in  1  invalidate strobe
i_inv_set  in  SET_W  set to invalidate
i_inv_way  in  WAY_W  way to invalidate
i_alloc_req  in  1  victim request, single-cycle pulse
i_alloc_set  in  SET_W  set to allocate in
o_alloc_valid  out  1  result strobe, 1 cycle after i_alloc_req
o_alloc_way_oh  out  NUM_WAYS  one-hot write enable of the chosen way
o_alloc_way  out  WAY_W  binary index of the chosen way
o_alloc_fail  out  1  all ways locked; no allocation made

Behaviour:
- State per set:
  - valid[NUM_WAYS]
  - rr_ptr[WAY_W]
  - plru[NUM_WAYS-1], heap-indexed: root 0, children 2n+1 and 2n+2.
- Reset (async, i_rst_n=0): all state 0. o_alloc_valid, o_alloc_way_oh, o_alloc_way and o_alloc_fail are 0 immediately.
- Output timing: all outputs are registered. o_alloc_valid is a one-cycle pulse in the cycle after i_alloc_req, otherwise 0. o_alloc_way_oh is 0 whenever o_alloc_valid is 0.
- Candidate set: cand = ~i_lock_mask.
- Victim selection, combinational on current state, priority order:
  1. If cand==0: fail. o_alloc_fail=1, way_oh=0, way=0, no state change.
  2. Else, if any cand way is invalid: pick the lowest-index invalid cand way.
  3. Else, RR mode: pick the first cand way scanning up from rr_ptr, wrapping at NUM_WAYS.
  4. Else, PLRU mode: descend the tree (bit 0 → left subtree, bit 1 → right) to a leaf way. If that way is locked, pick the lowest-index cand way instead.
- On a successful alloc, at the same edge that registers the outputs:
  - valid[chosen]=1
  - rr_ptr=(chosen+1) mod NUM_WAYS
  - PLRU touch(chosen).
  - These updates apply in both modes, so the inactive policy state stays coherent.
- touch(w): each node on w's path is set to point away from w (1 if w is in the left subtree, 0 if in the right).
- Access: i_acc_valid performs touch(i_acc_way) on i_acc_set only. Valid bits and rr_ptr are unchanged.
- Invalidate: valid[i_inv_way]=0 in i_inv_set. PLRU and rr_ptr are unchanged.
- Simultaneous events in the same cycle:
  - Selection always uses pre-edge state.
  - Next-state order: access touch, then invalidate, then alloc update. The alloc update wins on shared PLRU bits and on the valid bit of the same way.
  - Different sets update independently.
- Flush:
  - i_flush=1 clears all state at the edge.
  - An alloc in the same cycle is dropped: o_alloc_valid=0 next cycle, no fail.
  - Access and invalidate in that cycle are ignored.
- Mode switch: no state is cleared. The new policy takes effect on the next alloc.
- Lock mask changes take effect the same cycle; no state is modified by them.

Test Plan:
- Reset, mode=0, lock=0000, 4 allocs to set 2 on consecutive cycles → o_alloc_way_oh 0001, 0010, 0100, 1000, each with o_alloc_valid 1 cycle after its request. Then rr_ptr[2]=0, and a 5th alloc → 0001.
- Mode=1: fill set 1 (ways 0..3), then access set 1 way 0, then alloc set 1 → way_oh 0100 (way 2). Set 0 untouched: its next alloc → 0001.
- Mode=0, set 3 full, rr_ptr=0, lock=0101 → allocs give 0010, 1000, 0010. Then lock=1111 → o_alloc_fail=1, way_oh=0000, no state change.
- Mode=1, set 0 full, invalidate way 3 in the same cycle as access way 1; next alloc set 0 → 1000 (invalid way wins over PLRU). Alloc and invalidate of the same way in one cycle → way remains valid.
- Flush together with alloc → no o_alloc_valid next cycle; the following alloc on any set → 0001.
- Drop i_rst_n mid-cycle while o_alloc_valid=1 → all outputs 0 immediately. After release, an alloc → 0001.

Source files
------------

// File: rtl/cache_repl_ctrl.sv
// cache_repl_ctrl: way-replacement controller for the set-associative cache.
// It tracks per-set valid bits, a round-robin pointer and tree-PLRU bits.
// On an allocation request it returns the victim way one cycle later, both as
// a registered one-hot write enable and as a binary index.
module cache_repl_ctrl #(
    parameter int NUM_SETS = 4,
    parameter int NUM_WAYS = 4,
    parameter int SET_W    = $clog2(NUM_SETS),
    parameter int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_mode,
    input  logic                i_flush,
    input  logic [NUM_WAYS-1:0] i_lock_mask,
    input  logic                i_acc_valid,
    input  logic [SET_W-1:0]    i_acc_set,
    input  logic [WAY_W-1:0]    i_acc_way,
    input  logic                i_inv_valid,
    input  logic [SET_W-1:0]    i_inv_set,
    input  logic [WAY_W-1:0]    i_inv_way,
    input  logic                i_alloc_req,
    input  logic [SET_W-1:0]    i_alloc_set,
    output logic                o_alloc_valid,
    output logic [NUM_WAYS-1:0] o_alloc_way_oh,
    output logic [WAY_W-1:0]    o_alloc_way,
    output logic                o_alloc_fail
);

    // Width of an index into the PLRU node vector (NUM_WAYS-1 nodes).
    localparam int NODE_W = (NUM_WAYS > 2) ? $clog2(NUM_WAYS - 1) : 1;

    // Per-set replacement state, packed so a flush clears it in one assignment.
    logic [NUM_SETS-1:0][NUM_WAYS-1:0] r_valid;
    logic [NUM_SETS-1:0][WAY_W-1:0]    r_rrPtr;
    logic [NUM_SETS-1:0][NUM_WAYS-2:0] r_plru;

    // Registered result of the most recent request.
    logic                r_allocValid;
    logic [NUM_WAYS-1:0] r_allocWayOh;
    logic [WAY_W-1:0]    r_allocWay;
    logic                r_allocFail;

    // Victim selection terms, all derived from pre-edge state.
    logic [NUM_WAYS-1:0] w_cand;
    logic [NUM_WAYS-1:0] w_freeCand;
    logic                w_fail;
    logic                w_anyFree;
    logic [WAY_W-1:0]    w_lowestCand;
    logic [WAY_W-1:0]    w_lowestFree;
    logic [WAY_W-1:0]    w_rrWay;
    logic [WAY_W-1:0]    w_plruWay;
    logic [WAY_W-1:0]    w_victim;
    logic                w_allocOk;

    // PLRU next values for the access set and for the allocation set.
    logic [NUM_WAYS-2:0] w_plruAcc;
    logic [NUM_WAYS-2:0] w_plruAllocBase;
    logic [NUM_WAYS-2:0] w_plruAlloc;

    // Lowest-index set bit of a way vector; 0 when the vector is empty.
    function automatic logic [WAY_W-1:0] lowestSet(input logic [NUM_WAYS-1:0] vec);
        logic [WAY_W-1:0] res;
        res = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (vec[WAY_W'(i)]) begin
                res = WAY_W'(i);
            end
        end
        return res;
    endfunction

    // First candidate way scanning upward from ptr, wrapping at NUM_WAYS.
    // Index arithmetic wraps naturally because NUM_WAYS is a power of two.
    function automatic logic [WAY_W-1:0] rrPick(input logic [NUM_WAYS-1:0] cand,
                                                input logic [WAY_W-1:0]    ptr);
        logic [WAY_W-1:0] res;
        logic [WAY_W-1:0] idx;
        res = '0;
        for (int k = NUM_WAYS - 1; k >= 0; k--) begin
            idx = ptr + WAY_W'(k);
            if (cand[idx]) begin
                res = idx;
            end
        end
        return res;
    endfunction

    // Walk the heap-ordered tree from the root; each visited bit becomes the
    // next way-index bit, MSB first (0 = left child, 1 = right child).
    function automatic logic [WAY_W-1:0] plruWalk(input logic [NUM_WAYS-2:0] bits);
        logic [WAY_W-1:0] prefix;
        int               node;
        prefix = '0;
        for (int l = 0; l < WAY_W; l++) begin
            node   = (1 << l) - 1 + int'(prefix);
            prefix = (prefix << 1) | WAY_W'(bits[NODE_W'(node)]);
        end
        return prefix;
    endfunction

    // Point every node on the path to 'way' away from it: a node whose path
    // bit is 0 (way lies to the left) becomes 1, and vice versa.
    function automatic logic [NUM_WAYS-2:0] plruTouch(input logic [NUM_WAYS-2:0] bits,
                                                      input logic [WAY_W-1:0]    way);
        logic [NUM_WAYS-2:0] res;
        logic [WAY_W-1:0]    prefix;
        logic                dir;
        int                  node;
        res    = bits;
        prefix = '0;
        for (int l = 0; l < WAY_W; l++) begin
            dir    = way[WAY_W'(WAY_W - 1 - l)];
            node   = (1 << l) - 1 + int'(prefix);
            res[NODE_W'(node)] = ~dir;
            prefix = (prefix << 1) | WAY_W'(dir);
        end
        return res;
    endfunction

    // Choose the victim: free candidate first, then the active policy,
    // with a locked PLRU leaf falling back to the lowest candidate.
    always_comb begin
        w_cand       = ~i_lock_mask;
        w_freeCand   = w_cand & ~r_valid[i_alloc_set];
        w_fail       = ~|w_cand;
        w_anyFree    = |w_freeCand;
        w_lowestCand = lowestSet(w_cand);
        w_lowestFree = lowestSet(w_freeCand);
        w_rrWay      = rrPick(w_cand, r_rrPtr[i_alloc_set]);
        w_plruWay    = plruWalk(r_plru[i_alloc_set]);
        w_victim     = '0;
        if (w_fail) begin
            w_victim = '0;
        end else if (w_anyFree) begin
            w_victim = w_lowestFree;
        end else if (!i_mode) begin
            w_victim = w_rrWay;
        end else if (w_cand[w_plruWay]) begin
            w_victim = w_plruWay;
        end else begin
            w_victim = w_lowestCand;
        end
        w_allocOk = i_alloc_req & ~w_fail & ~i_flush;
    end

    // Build the PLRU updates; when access and alloc hit the same set the
    // alloc touch is layered on top of the access touch so it wins on
    // shared nodes while the access still lands on the others.
    always_comb begin
        w_plruAcc       = plruTouch(r_plru[i_acc_set], i_acc_way);
        w_plruAllocBase = r_plru[i_alloc_set];
        if (i_acc_valid && (i_acc_set == i_alloc_set)) begin
            w_plruAllocBase = w_plruAcc;
        end
        w_plruAlloc = plruTouch(w_plruAllocBase, w_victim);
    end

    // Replacement state: flush clears everything, otherwise apply access,
    // invalidate and alloc in that order so later writes take precedence.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_rrPtr <= '0;
            r_plru  <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
            r_rrPtr <= '0;
            r_plru  <= '0;
        end else begin
            if (i_acc_valid) begin
                r_plru[i_acc_set] <= w_plruAcc;
            end
            if (i_inv_valid) begin
                r_valid[i_inv_set][i_inv_way] <= 1'b0;
            end
            if (w_allocOk) begin
                r_valid[i_alloc_set][w_victim] <= 1'b1;
                r_rrPtr[i_alloc_set]           <= w_victim + WAY_W'(1);
                r_plru[i_alloc_set]            <= w_plruAlloc;
            end
        end
    end

    // Result registers: a request produces a one-cycle strobe unless it is
    // swallowed by a flush; a fully locked set reports failure with no way.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_allocValid <= 1'b0;
            r_allocWayOh <= '0;
            r_allocWay   <= '0;
            r_allocFail  <= 1'b0;
        end else begin
            r_allocValid <= i_alloc_req & ~i_flush;
            r_allocFail  <= i_alloc_req & ~i_flush & w_fail;
            if (w_allocOk) begin
                r_allocWayOh <= NUM_WAYS'(1) << w_victim;
                r_allocWay   <= w_victim;
            end else begin
                r_allocWayOh <= '0;
                r_allocWay   <= '0;
            end
        end
    end

    assign o_alloc_valid  = r_allocValid;
    assign o_alloc_way_oh = r_allocWayOh;
    assign o_alloc_way    = r_allocWay;
    assign o_alloc_fail   = r_allocFail;

endmodule
